// File: rtl/i2c_calc_pkg.sv
// i2c_calc_pkg: shared types and constants for the I2C calculator bus master.
//   op_e    : command opcode carried on cmd_op
//   state_e : controller state
//   rsp_t   : response payload (read byte + ack flag)
package i2c_calc_pkg;

  localparam int unsigned NUM_BITS  = 9;   // 8 data bits + ack/nack bit
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HELD  = 3'd1,
    ST_START = 3'd2,
    ST_BIT   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0] rdata;
    logic       ack;
  } rsp_t;

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: divides clk into SCL quarter periods of CLK_DIV cycles.
//   clk, rst   : clock, synchronous active-high reset
//   i_restart  : begin a fresh quarter 0
//   i_stall    : hold the count (target clock stretching)
//   o_tick_c   : one-cycle pulse on the last cycle of a quarter
//   o_quarter  : index of the current quarter (0..3)
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_restart,
  input  logic       i_stall,
  output logic       o_tick_c,
  output logic [1:0] o_quarter
);

  localparam int unsigned      CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_quarter;

  assign o_tick_c  = (r_cnt == '0) && !i_stall;
  assign o_quarter = r_quarter;

  // Down-counter; the quarter index advances on each tick.
  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_cnt     <= CNT_MAX;
      r_quarter <= 2'd0;
    end else if (o_tick_c) begin
      r_cnt     <= CNT_MAX;
      r_quarter <= r_quarter + 2'd1;
    end else if (!i_stall) begin
      r_cnt     <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_calc_master.sv
// i2c_calc_master: byte-level I2C bus master (START / WRITE / READ / STOP).
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake; cmd_op, cmd_wdata, cmd_nack payload
//   rsp_valid                : one-cycle completion pulse; rsp_rdata, rsp_ack payload
//   busy                     : master owns the bus
//   scl_oe/sda_oe            : open-drain pull-downs; scl_in/sda_in sampled lines
// Build option: define I2C_CLK_STRETCH_EN to honour target clock stretching.
module i2c_calc_master
  import i2c_calc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_ack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(NUM_BITS - 1);

  state_e               r_state, w_nxt_state;
  logic [BIT_CNT_W-1:0] r_bit, w_nxt_bit;
  logic [7:0]           r_sh, w_nxt_sh;
  logic                 r_is_read, w_nxt_is_read;
  logic                 r_nack, w_nxt_nack;
  logic                 r_sda9, w_nxt_sda9;
  logic                 r_scl_oe, w_nxt_scl_oe;
  logic                 r_sda_oe, w_nxt_sda_oe;
  logic                 r_busy, w_nxt_busy;
  logic                 r_rsp_valid, w_nxt_rsp_valid;
  rsp_t                 r_rsp, w_nxt_rsp;
  logic                 r_cmd_ready, w_nxt_cmd_ready;

  logic       w_accept, w_tick, w_stall;
  logic [1:0] w_quarter;
  op_e        w_op;

  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_op     = op_e'(cmd_op);

`ifdef I2C_CLK_STRETCH_EN
  // Target may hold SCL low while we have it released.
  assign w_stall = !r_scl_oe && !scl_in && (r_state inside {ST_START, ST_BIT, ST_STOP});
`else
  logic w_unused_scl_in;
  assign w_unused_scl_in = scl_in;
  assign w_stall         = 1'b0;
`endif

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_accept),
    .i_stall   (w_stall),
    .o_tick_c  (w_tick),
    .o_quarter (w_quarter)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit       <= '0;
      r_sh        <= '0;
      r_is_read   <= 1'b0;
      r_nack      <= 1'b0;
      r_sda9      <= 1'b1;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_bit       <= w_nxt_bit;
      r_sh        <= w_nxt_sh;
      r_is_read   <= w_nxt_is_read;
      r_nack      <= w_nxt_nack;
      r_sda9      <= w_nxt_sda9;
      r_scl_oe    <= w_nxt_scl_oe;
      r_sda_oe    <= w_nxt_sda_oe;
      r_busy      <= w_nxt_busy;
      r_rsp_valid <= w_nxt_rsp_valid;
      r_rsp       <= w_nxt_rsp;
      r_cmd_ready <= w_nxt_cmd_ready;
    end
  end

  // Next state; line levels change at the edge that opens each quarter.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_bit       = r_bit;
    w_nxt_sh        = r_sh;
    w_nxt_is_read   = r_is_read;
    w_nxt_nack      = r_nack;
    w_nxt_sda9      = r_sda9;
    w_nxt_scl_oe    = r_scl_oe;
    w_nxt_sda_oe    = r_sda_oe;
    w_nxt_busy      = r_busy;
    w_nxt_rsp_valid = 1'b0;
    w_nxt_rsp       = r_rsp;

    unique case (r_state)
      ST_IDLE, ST_HELD: begin
        if (w_accept) begin
          if (w_op == OP_START) begin
            w_nxt_state  = ST_START;
            w_nxt_sda_oe = 1'b0;
          end else if (r_state == ST_IDLE) begin
            // Data or STOP without owning the bus: answer at once, no bus activity.
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp       = '0;
          end else if (w_op == OP_STOP) begin
            w_nxt_state  = ST_STOP;
            w_nxt_scl_oe = 1'b1;
            w_nxt_sda_oe = 1'b1;
          end else begin
            w_nxt_state   = ST_BIT;
            w_nxt_bit     = '0;
            w_nxt_is_read = (w_op == OP_READ);
            w_nxt_sh      = cmd_wdata;
            w_nxt_nack    = cmd_nack;
            w_nxt_scl_oe  = 1'b1;
            w_nxt_sda_oe  = (w_op == OP_WRITE) ? !cmd_wdata[7] : 1'b0;
          end
        end
      end

      ST_START: begin
        if (w_tick) begin
          case (w_quarter)
            2'd0:    w_nxt_scl_oe = 1'b0;
            2'd1:    w_nxt_sda_oe = 1'b1;
            2'd2:    w_nxt_scl_oe = 1'b1;
            default: begin
              w_nxt_state     = ST_HELD;
              w_nxt_busy      = 1'b1;
              w_nxt_rsp_valid = 1'b1;
              w_nxt_rsp       = '{rdata: 8'h00, ack: 1'b1};
            end
          endcase
        end
      end

      ST_BIT: begin
        if (w_tick) begin
          case (w_quarter)
            2'd0:    ;
            2'd1:    w_nxt_scl_oe = 1'b0;
            2'd2: begin
              if (r_bit == LAST_BIT) w_nxt_sda9 = sda_in;
              else                   w_nxt_sh   = {r_sh[6:0], sda_in};
            end
            default: begin
              w_nxt_scl_oe = 1'b1;
              if (r_bit == LAST_BIT) begin
                w_nxt_state     = ST_HELD;
                w_nxt_rsp_valid = 1'b1;
                w_nxt_rsp.rdata = r_is_read ? r_sh : 8'h00;
                w_nxt_rsp.ack   = r_is_read ? 1'b1 : !r_sda9;
              end else begin
                w_nxt_bit = r_bit + 1'b1;
                // r_sh has already shifted, so bit 7 is the next data bit.
                if (r_bit == LAST_BIT - 1'b1) w_nxt_sda_oe = r_is_read ? !r_nack : 1'b0;
                else                          w_nxt_sda_oe = r_is_read ? 1'b0 : !r_sh[7];
              end
            end
          endcase
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          case (w_quarter)
            2'd0:    w_nxt_scl_oe = 1'b0;
            2'd1:    w_nxt_sda_oe = 1'b0;
            2'd2:    ;
            default: begin
              w_nxt_state     = ST_IDLE;
              w_nxt_busy      = 1'b0;
              w_nxt_rsp_valid = 1'b1;
              w_nxt_rsp       = '{rdata: 8'h00, ack: 1'b1};
            end
          endcase
        end
      end

      default: w_nxt_state = ST_IDLE;
    endcase

    w_nxt_cmd_ready = ((w_nxt_state == ST_IDLE) || (w_nxt_state == ST_HELD)) && !w_nxt_rsp_valid;
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp.rdata;
  assign rsp_ack   = r_rsp.ack;
  assign busy      = r_busy;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_i2c_calc_master.sv
// Directed bench for i2c_calc_master with CLK_DIV=4 and a small I2C target model.
module tb_i2c_calc_master;
  import i2c_calc_pkg::*;

  localparam int unsigned CD = 4;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_nack;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ack, busy, scl_oe, sda_oe;
  logic [7:0] rsp_rdata;
  logic       scl_line, sda_line;

  // Target model state (main thread writes mode/byte/base/stretch, monitor writes counters)
  int         tgt_mode;      // 0 silent, 1 ack 9th bit, 2 drive tgt_byte
  logic [7:0] tgt_byte;
  int         tgt_base;
  logic       tgt_scl_low;
  logic       tgt_sda_low;
  int         tgt_falls, rises, starts, stops, oe_cycles;
  int         rise_base;
  logic       log_sda [256];
  logic       log_oe  [256];
  logic       prev_scl, prev_sda;

  int total, bad;
  int lat, n, cnt, s0, p0;
  logic [7:0] byte_v;

  i2c_calc_master #(.CLK_DIV(CD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_wdata (cmd_wdata),
    .cmd_nack  (cmd_nack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_ack   (rsp_ack),
    .busy      (busy),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .scl_in    (scl_line),
    .sda_in    (sda_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic tgt_pull(input int m, input int rel, input logic [7:0] b);
    if (m == 1) return (rel == 8);
    if (m == 2 && rel >= 0 && rel < 8) return !b[7-rel];
    return 1'b0;
  endfunction

  assign tgt_sda_low = tgt_pull(tgt_mode, tgt_falls - tgt_base, tgt_byte);
  assign scl_line    = !scl_oe && !tgt_scl_low;
  assign sda_line    = !sda_oe && !tgt_sda_low;

  // Bus monitor, sampled mid-cycle so simultaneous edges are seen together.
  always @(negedge clk) begin
    if (prev_scl && !scl_line) tgt_falls <= tgt_falls + 1;
    if (!prev_scl && scl_line) begin
      log_sda[rises & 255] <= sda_line;
      log_oe[rises & 255]  <= sda_oe;
      rises <= rises + 1;
    end
    if (prev_scl && scl_line && prev_sda && !sda_line) starts <= starts + 1;
    if (prev_scl && scl_line && !prev_sda && sda_line) stops <= stops + 1;
    if (scl_oe || sda_oe) oe_cycles <= oe_cycles + 1;
    prev_scl <= scl_line;
    prev_sda <= sda_line;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge; returns on negedge 1 after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] wd, input logic nk);
    int k;
    k = 0;
    cmd_op = op; cmd_wdata = wd; cmd_nack = nk; cmd_valid = 1'b1;
    while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    tgt_base  = tgt_falls;
    rise_base = rises;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // lat = number of edges from accept to the edge that sees rsp_valid high.
  task automatic wait_rsp(input int n0, output int l);
    l = n0;
    while (!rsp_valid && l < 3000) begin @(negedge clk); l++; end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 0; i < 8; i++) b[7-i] = log_sda[(rise_base + i) & 255];
  endtask

  initial begin
    total = 0; bad = 0;
    tgt_mode = 0; tgt_byte = 8'h00; tgt_base = 0; tgt_scl_low = 1'b0;
    tgt_falls = 0; rises = 0; starts = 0; stops = 0; oe_cycles = 0; rise_base = 0;
    prev_scl = 1'b1; prev_sda = 1'b1;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = 8'h00; cmd_nack = 1'b0;

    // Reset values
    @(posedge clk); @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_outputs", {rsp_valid, rsp_ack, busy, scl_oe, sda_oe, rsp_rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Illegal READ in IDLE
    cnt = oe_cycles;
    issue(OP_READ, 8'h00, 1'b0);
    wait_rsp(1, lat);
    chk("illegal_lat", 32'(lat), 32'd1);
    chk("illegal_ack", 32'(rsp_ack), 32'd0);
    chk("illegal_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("illegal_ready_back", 32'(cmd_ready), 32'd1);
    issue(OP_STOP, 8'h00, 1'b0);
    wait_rsp(1, lat);
    chk("illegal_stop_ack", {lat[7:0], 7'd0, rsp_ack}, {8'd1, 8'd0});
    repeat (3) @(negedge clk);
    chk("illegal_no_oe", 32'(oe_cycles - cnt), 32'd0);

    // START, WRITE 0x54 acked, STOP
    s0 = starts;
    issue(OP_START, 8'h00, 1'b0);
    wait_rsp(1, lat);
    chk("start_lat", 32'(lat), 32'(4*CD+1));
    chk("start_ack_busy", {rsp_ack, busy}, 32'b11);
    chk("start_seen", 32'(starts - s0), 32'd1);
    tgt_mode = 1;
    issue(OP_WRITE, 8'h54, 1'b0);
    wait_rsp(1, lat);
    chk("write_lat", 32'(lat), 32'(36*CD+1));
    chk("write_ack", 32'(rsp_ack), 32'd1);
    read_byte(byte_v);
    chk("write_bits", 32'(byte_v), 32'h54);
    chk("write_bit9_low", 32'(log_sda[(rise_base + 8) & 255]), 32'd0);
    tgt_mode = 0;
    p0 = stops;
    issue(OP_STOP, 8'h00, 1'b0);
    wait_rsp(1, lat);
    chk("stop_lat", 32'(lat), 32'(4*CD+1));
    chk("stop_seen", 32'(stops - p0), 32'd1);
    @(negedge clk);
    chk("stop_idle", {busy, scl_oe, sda_oe}, 32'd0);

    // WRITE 0xFF with no target
    issue(OP_START, 8'h00, 1'b0);
    wait_rsp(1, lat);
    issue(OP_WRITE, 8'hFF, 1'b0);
    wait_rsp(1, lat);
    chk("nack_ack", 32'(rsp_ack), 32'd0);
    @(negedge clk);
    chk("nack_held", {busy, scl_oe, cmd_ready}, 32'b111);

    // WRITE 0x55, repeated START, READ 0xA5 with NACK, STOP
    tgt_mode = 1;
    issue(OP_WRITE, 8'h55, 1'b0);
    wait_rsp(1, lat);
    chk("w55_ack", 32'(rsp_ack), 32'd1);
    read_byte(byte_v);
    chk("w55_bits", 32'(byte_v), 32'h55);
    tgt_mode = 0;
    s0 = starts; p0 = stops;
    issue(OP_START, 8'h00, 1'b0);
    wait_rsp(1, lat);
    chk("rstart_seen", {starts - s0, stops - p0}, {32'd1, 32'd0});
    tgt_byte = 8'hA5; tgt_mode = 2;
    issue(OP_READ, 8'h00, 1'b1);
    wait_rsp(1, lat);
    chk("read_lat", 32'(lat), 32'(36*CD+1));
    chk("read_data", 32'(rsp_rdata), 32'hA5);
    chk("read_ack", 32'(rsp_ack), 32'd1);
    chk("read_bit9", {log_sda[(rise_base + 8) & 255], log_oe[(rise_base + 8) & 255]}, 32'b10);
    tgt_mode = 0;
    issue(OP_STOP, 8'h00, 1'b0);
    wait_rsp(1, lat);
    chk("stop2_ack", 32'(rsp_ack), 32'd1);

    // Reset during bit 4 of a WRITE
    @(negedge clk);
    issue(OP_START, 8'h00, 1'b0);
    wait_rsp(1, lat);
    issue(OP_WRITE, 8'h3C, 1'b0);
    n = 0;
    while ((rises - rise_base) < 4 && n < 500) begin @(negedge clk); n++; end
    chk("reached_bit4", 32'(rises - rise_base), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_lines", {scl_oe, sda_oe, rsp_valid, busy}, 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("rst_mid_no_rsp", 32'(cnt), 32'd0);
    chk("rst_mid_ready", {cmd_ready, scl_oe, sda_oe}, 32'b100);

`ifdef I2C_CLK_STRETCH_EN
    // Target stretches SCL for 10 cycles in bit 1
    issue(OP_START, 8'h00, 1'b0);
    wait_rsp(1, lat);
    issue(OP_WRITE, 8'h54, 1'b0);
    n = 1;
    while (scl_oe && n < 500) begin @(negedge clk); n++; end
    tgt_scl_low = 1'b1;
    repeat (10) begin @(negedge clk); n++; end
    tgt_scl_low = 1'b0;
    wait_rsp(n, lat);
    chk("stretch_lat", 32'(lat), 32'(36*CD+1+10));
    issue(OP_STOP, 8'h00, 1'b0);
    wait_rsp(1, lat);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_calc_master.md
# i2c_calc_master

Byte-level I2C controller (bus master) that drives the two-wire bus toward the I2C calculator target in `tt_um_bsrk_i2c_calc`. It serves as the bench and FPGA-side initiator that exercises the calculator. It accepts one primitive command at a time: START, WRITE byte, READ byte or STOP. It generates open-drain SCL/SDA, samples the target's ACK and read data, and returns exactly one response per command.

## Interface
Parameters:
- `CLK_DIV`, default 25: clk cycles per quarter SCL period; SCL = clk / (4·CLK_DIV); legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command can be accepted; transfer occurs when valid&ready on a rising clk edge.
- `cmd_op`  in  2  0 START, 1 WRITE, 2 READ, 3 STOP.
- `cmd_wdata`  in  8  byte for WRITE, sent MSB first.
- `cmd_nack`  in  1  for READ: 1 = master sends NACK (last byte), 0 = ACK.
- `rsp_valid`  out  1  one-cycle pulse; the command is complete.
- `rsp_rdata`  out  8  byte received by READ; 0 for other ops.
- `rsp_ack`  out  1  WRITE: 1 = target pulled SDA low on the 9th bit; START/STOP: 1; READ: 1; illegal op: 0.
- `busy`  out  1  master owns the bus (between START and completed STOP).
- `scl_oe`  out  1  1 = pull SCL low, 0 = release.
- `sda_oe`  out  1  1 = pull SDA low, 0 = release.
- `scl_in`  in  1  sampled SCL line (used only with stretching).
- `sda_in`  in  1  sampled SDA line.

## Operation
- States: IDLE (bus free; SCL and SDA released), HELD (bus owned; SCL low, SDA unchanged), START, BIT, STOP.
- `cmd_ready` = 1 only in IDLE or HELD, and not in the cycle `rsp_valid` is high.
- Each bus action is a sequence of quarters Q0–Q3, each CLK_DIV cycles long.
- START (from IDLE or HELD): Q0 release SDA (SCL unchanged); Q1 release SCL; Q2 pull SDA low; Q3 pull SCL low. Ends in HELD and sets `busy`. From HELD, this sequence is a repeated start.
- WRITE: 9 bits. Bits 1–8 drive `cmd_wdata[7-i]`; bit 9 releases SDA. Per bit: Q0–Q1 SCL low with SDA set at the start of Q0; Q2–Q3 SCL released. `sda_in` is sampled on the last cycle of Q2. `rsp_ack` = ~sda(bit 9).
- READ: same 9-bit framing. SDA is released for bits 1–8, shifting the samples in MSB first. Bit 9 drives `cmd_nack` (0 = pull low).
- STOP: Q0 SCL low, SDA low; Q1 release SCL; Q2 release SDA; Q3 both released (bus-free time). Ends in IDLE and clears `busy`.
- Illegal commands: WRITE or READ in IDLE, and STOP in IDLE. The command is accepted with no bus activity. `rsp_valid` fires on the next cycle with `rsp_ack`=0.
- A WRITE that receives a NACK does not auto-STOP; the master stays in HELD and the user issues STOP.

## Timing
- Latency from the accept edge to `rsp_valid`:
  - START or STOP: 4·CLK_DIV + 1 cycles.
  - WRITE or READ: 36·CLK_DIV + 1 cycles.
  - Illegal op: 1 cycle.
- `rsp_rdata` and `rsp_ack` are valid only while `rsp_valid` is high, and are held until the next response.
- Reset values: `cmd_ready`=0 for the reset cycle, then 1. `rsp_valid`=0, `rsp_rdata`=0, `rsp_ack`=0, `busy`=0, `scl_oe`=0, `sda_oe`=0.
- Reset asserted mid-transfer: both lines are released on the next edge, the pending response is dropped, and the state becomes IDLE. No STOP is generated.
- Back-to-back commands: a new command can be accepted on the cycle after `rsp_valid`.

## Configuration
- `I2C_CLK_STRETCH_EN` defined: during any quarter in which SCL is released, the quarter counter holds while `scl_in`=0 (target stretching). Latency grows by the number of stretched cycles.
- `I2C_CLK_STRETCH_EN` undefined: `scl_in` is ignored and timing is exactly as given above.

## Structure
- Package `i2c_calc_pkg`: the `cmd_op` enum (OP_START/OP_WRITE/OP_READ/OP_STOP), the FSM state enum, and the bit-count constant 9.
- Sub-module `i2c_quarter_tick`: CLK_DIV down-counter with a `stall` input (stretch) and a `restart` input. It emits a one-cycle `tick` at the end of each quarter plus a 2-bit quarter index.

## Test plan
- CLK_DIV=4, START, WRITE 0x54, target model ACKs, STOP:
  - SDA bit sequence 0,1,0,1,0,1,0,0.
  - `rsp_ack`=1.
  - WRITE `rsp_valid` exactly 145 cycles after accept.
  - `busy` ends at 0.
- WRITE 0xFF with the target not responding: `rsp_ack`=0 and the state stays HELD (`busy`=1, `scl_oe`=1).
- READ with the target driving 0xA5 and `cmd_nack`=1: `rsp_rdata`=0xA5 and SDA is released during bit 9.
- START, WRITE 0x55, START (repeated), READ: SDA falls while SCL is high with no intervening STOP.
- READ issued in IDLE: `rsp_valid` on the next cycle with `rsp_ack`=0; `scl_oe`/`sda_oe` never assert.
- `rst` pulsed during bit 4 of a WRITE: both oe signals 0 the next cycle, no `rsp_valid`, `cmd_ready`=1 afterward.
- With `I2C_CLK_STRETCH_EN`, the target holds SCL low 10 cycles in bit 1: `rsp_valid` arrives 10 cycles later.
